// File: rtl/ds_pkg.sv
// Shared types and helpers for the diamond-square terrain engine:
// FSM state encoding, LFSR tap masks, saturating add, grid geometry helpers.
package ds_pkg;

  localparam int XY_W = 10;
  localparam int DS_DIM_POWER_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORNERS,
    ST_DIAMOND,
    ST_SQUARE,
    ST_STREAM
  } ds_state_e;

  function automatic int ds_dim(input int p);
    return (1 << p) + 1;
  endfunction

  function automatic int ds_idx_w(input int p);
    return $clog2(ds_dim(p) * ds_dim(p));
  endfunction

  localparam int DS_DIM   = ds_dim(DS_DIM_POWER_DEF);
  localparam int DS_D     = DS_DIM - 1;
  localparam int DS_IDX_W = ds_idx_w(DS_DIM_POWER_DEF);

  // Bit mask of feedback taps (bit n-1 for tap n) for a maximal-length Fibonacci LFSR.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    case (w)
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      24:      t = 32'h00E1_0000;
      default: t = 32'h8020_0003;
    endcase
    return t;
  endfunction

  function automatic int sat_add(input int a, input int b, input int hi);
    int r;
    r = a + b;
    if (r < 0) r = 0;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/ds_lfsr.sv
// Fibonacci noise LFSR; load takes priority over advance, a zero seed loads as 1.
module ds_lfsr
  import ds_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  always_ff @(posedge clk) begin
    if (reset)
      q <= LFSR_W'(1);
    else if (load)
      q <= (seed == '0) ? LFSR_W'(1) : seed;
    else if (adv)
      q <= {q[LFSR_W-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/ds_terrain_engine.sv
// Diamond-square heightmap generator: fills the grid one point per clock, then streams it row-major.
// Build option WRAP_EDGES_EN: square-step edge neighbours wrap (tileable) instead of reflecting.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_CORNERS | seeding the four corners from the LFSR
//   ST_DIAMOND | centre points of the current level
//   ST_SQUARE  | edge midpoints of the current level
//   ST_STREAM  | emitting (x,y,z) beats
module ds_terrain_engine
  import ds_pkg::*;
#(
  parameter int DIM_POWER = 3,
  parameter int H_W       = 8,
  parameter int LFSR_W    = 16,
  parameter int ROUGH     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XY_W-1:0]   out_x,
  output logic [XY_W-1:0]   out_y,
  output logic [H_W-1:0]    out_z,
  output logic              out_last
);

  localparam int DIM  = ds_dim(DIM_POWER);
  localparam int AW   = ds_idx_w(DIM_POWER);
  localparam int ZMAX = (1 << H_W) - 1;
  localparam logic [XY_W-1:0] D = XY_W'(DIM - 1);

  ds_state_e state;
  logic [H_W-1:0] grid [DIM*DIM];
  logic [XY_W-1:0] px, py;
  logic [3:0] lvl;
  logic [1:0] corner;
  logic [LFSR_W-1:0] lfsr_q;
  logic lfsr_load, we;

  logic [XY_W-1:0] s, h, up_y, dn_y, lf_x, rt_x, nx, ny;
  logic [XY_W-1:0] rx [4];
  logic [XY_W-1:0] ry [4];
  logic [H_W-1:0] rz [4];
  logic [H_W+1:0] sum;
  logic [H_W-1:0] wz;
  int nsh, noise, zval;

  function automatic logic [AW-1:0] addr_of(input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
    int a;
    a = int'(y) * DIM + int'(x);
    return a[AW-1:0];
  endfunction

  assign s = XY_W'(1) << lvl;
  assign h = XY_W'(1) << (lvl - 4'd1);
  assign we = (state == ST_CORNERS) || (state == ST_DIAMOND) || (state == ST_SQUARE);
  assign lfsr_load = (state == ST_IDLE) && start;

  ds_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .adv   (we),
    .q     (lfsr_q)
  );

  always_comb begin
    nx = (out_x == D) ? '0 : out_x + 1'b1;
    ny = (out_x == D) ? out_y + 1'b1 : out_y;
`ifdef WRAP_EDGES_EN
    up_y = (py < h) ? D - h : py - h;
    dn_y = (py + h > D) ? h : py + h;
    lf_x = (px < h) ? D - h : px - h;
    rt_x = (px + h > D) ? h : px + h;
`else
    up_y = (py < h) ? h : py - h;
    dn_y = (py + h > D) ? D - h : py + h;
    lf_x = (px < h) ? h : px - h;
    rt_x = (px + h > D) ? D - h : px + h;
`endif
    for (int i = 0; i < 4; i++) begin
      rx[i] = '0;
      ry[i] = '0;
    end
    case (state)
      ST_DIAMOND: begin
        rx[0] = px - h; ry[0] = py - h;
        rx[1] = px + h; ry[1] = py - h;
        rx[2] = px - h; ry[2] = py + h;
        rx[3] = px + h; ry[3] = py + h;
      end
      ST_SQUARE: begin
        rx[0] = px;   ry[0] = up_y;
        rx[1] = lf_x; ry[1] = py;
        rx[2] = rt_x; ry[2] = py;
        rx[3] = px;   ry[3] = dn_y;
      end
      ST_STREAM: begin
        // Port 0 prefetches the next beat so out_z can stay registered.
        if (!out_last) begin
          rx[0] = nx;
          ry[0] = ny;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++)
      rz[i] = grid[addr_of(rx[i], ry[i])];
  end

  always_comb begin
    sum = {2'b00, rz[0]} + {2'b00, rz[1]} + {2'b00, rz[2]} + {2'b00, rz[3]};
    nsh = DIM_POWER - int'(lvl) + ROUGH;
    noise = int'($signed(lfsr_q[H_W-1:0]));
    noise = (nsh >= H_W) ? 0 : (noise >>> nsh);
    zval = sat_add(int'(sum >> 2), noise, ZMAX);
    wz = (state == ST_CORNERS) ? lfsr_q[H_W-1:0] : zval[H_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (we)
      grid[addr_of(px, py)] <= wz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      px        <= '0;
      py        <= '0;
      lvl       <= '0;
      corner    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_CORNERS;
            busy   <= 1'b1;
            px     <= '0;
            py     <= '0;
            corner <= '0;
            lvl    <= 4'(DIM_POWER);
          end
        end
        ST_CORNERS: begin
          corner <= corner + 2'd1;
          case (corner)
            2'd0:    begin px <= D;  py <= '0; end
            2'd1:    begin px <= '0; py <= D;  end
            2'd2:    begin px <= D;  py <= D;  end
            default: begin state <= ST_DIAMOND; px <= h; py <= h; end
          endcase
        end
        ST_DIAMOND: begin
          if (px + s > D) begin
            px <= h;
            if (py + s > D) begin
              state <= ST_SQUARE;
              py    <= '0;
            end else begin
              py <= py + s;
            end
          end else begin
            px <= px + s;
          end
        end
        ST_SQUARE: begin
          if (px + s > D) begin
            if (py + h > D) begin
              if (lvl == 4'd1) begin
                state     <= ST_STREAM;
                out_valid <= 1'b1;
                out_x     <= '0;
                out_y     <= '0;
                out_z     <= grid[0];
                out_last  <= 1'b0;
              end else begin
                state <= ST_DIAMOND;
                lvl   <= lvl - 4'd1;
                px    <= h >> 1;
                py    <= h >> 1;
              end
            end else begin
              // Odd rows of the h-lattice start at x=0, even rows at x=h.
              py <= py + h;
              px <= (((py + h) & h) != '0) ? '0 : h;
            end
          end else begin
            px <= px + s;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_x     <= '0;
              out_y     <= '0;
              out_z     <= '0;
            end else begin
              out_x    <= nx;
              out_y    <= ny;
              out_z    <= rz[0];
              out_last <= (nx == D) && (ny == D);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_terrain_engine.sv
// Bench for ds_terrain_engine: three instances (DIM_POWER 1/2/3) checked against a grid-level model.
// Honours WRAP_EDGES_EN the same way as the design build.
module tb_ds_terrain_engine;

  localparam int N = 3;

  function automatic int dp_of(input int g);
    return g + 1;
  endfunction

  function automatic int rough_of(input int g);
    return (g == 2) ? 0 : 8;
  endfunction

  logic        clk, reset, out_ready;
  logic        start     [N];
  logic [15:0] seed      [N];
  logic        busy      [N];
  logic        out_valid [N];
  logic [9:0]  out_x     [N];
  logic [9:0]  out_y     [N];
  logic [7:0]  out_z     [N];
  logic        out_last  [N];

  int n_chk = 0;
  int n_fail = 0;
  int ready_mode = 0;
  logic mon_en = 1'b0;
  logic [28:0] got [N][81];
  int got_n [N];
  int fill_cnt [N];
  logic done [N];
  int mz [9][9];
  logic [15:0] ml;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ds_terrain_engine #(
      .DIM_POWER (dp_of(g)),
      .H_W       (8),
      .LFSR_W    (16),
      .ROUGH     (rough_of(g))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start[g]),
      .seed      (seed[g]),
      .busy      (busy[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_x     (out_x[g]),
      .out_y     (out_y[g]),
      .out_z     (out_z[g]),
      .out_last  (out_last[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] pack_beat(input logic [9:0] x, input logic [9:0] y,
                                            input logic [7:0] z, input logic l);
    return {x, y, z, l};
  endfunction

  // Beat capture, stall-hold and end-of-stream checks, sampled mid-cycle.
  for (genvar g = 0; g < N; g++) begin : g_mon
    logic [28:0] snap = '0;
    logic stalled = 1'b0;
    logic idle_pend = 1'b0;
    always @(negedge clk) begin
      if (mon_en) begin
        if (idle_pend) begin
          chk($sformatf("d%0d_idle_after_last", g), {busy[g], out_valid[g]}, 2'b00);
          idle_pend = 1'b0;
        end
        if (stalled)
          chk($sformatf("d%0d_hold", g), pack_beat(out_x[g], out_y[g], out_z[g], out_last[g]), snap);
        stalled = out_valid[g] && !out_ready;
        snap = pack_beat(out_x[g], out_y[g], out_z[g], out_last[g]);
        if (busy[g] && !out_valid[g])
          fill_cnt[g]++;
        if (out_valid[g] && out_ready) begin
          chk($sformatf("d%0d_busy_stream", g), busy[g], 1);
          if (got_n[g] < 81)
            got[g][got_n[g]] = snap;
          got_n[g]++;
          if (out_last[g]) begin
            done[g] = 1'b1;
            idle_pend = 1'b1;
          end
        end
      end else begin
        stalled = 1'b0;
        idle_pend = 1'b0;
      end
    end
  end

  initial begin
    int phase;
    phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      if (ready_mode == 0)
        out_ready = (phase % 3 == 0);
      else
        out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
  endfunction

  function automatic int fold(input int v, input int d, input int h);
`ifdef WRAP_EDGES_EN
    if (v < 0) return d - h;
    if (v > d) return h;
`else
    if (v < 0) return -v;
    if (v > d) return 2 * d - v;
`endif
    return v;
  endfunction

  task automatic model_put(input int x, input int y, input int sum4, input int sh);
    int n;
    n = int'($signed(ml[7:0]));
    n = (sh >= 8) ? 0 : (n >>> sh);
    n = sum4 / 4 + n;
    if (n < 0) n = 0;
    if (n > 255) n = 255;
    mz[y][x] = n;
    ml = lfsr_next(ml);
  endtask

  task automatic model_run(input int dp, input int rough, input logic [15:0] sd);
    int d, h, k;
    d = 1 << dp;
    ml = (sd == 16'h0) ? 16'h1 : sd;
    mz[0][0] = int'(ml[7:0]); ml = lfsr_next(ml);
    mz[0][d] = int'(ml[7:0]); ml = lfsr_next(ml);
    mz[d][0] = int'(ml[7:0]); ml = lfsr_next(ml);
    mz[d][d] = int'(ml[7:0]); ml = lfsr_next(ml);
    k = dp;
    for (int s = d; s >= 2; s = s / 2) begin
      h = s / 2;
      for (int y = h; y < d; y += s)
        for (int x = h; x < d; x += s)
          model_put(x, y, mz[y-h][x-h] + mz[y-h][x+h] + mz[y+h][x-h] + mz[y+h][x+h], dp - k + rough);
      for (int y = 0; y <= d; y += h)
        for (int x = 0; x <= d; x += h)
          if ((x / h + y / h) % 2 == 1)
            model_put(x, y, mz[fold(y-h, d, h)][x] + mz[fold(y+h, d, h)][x]
                          + mz[y][fold(x-h, d, h)] + mz[y][fold(x+h, d, h)], dp - k + rough);
      k--;
    end
  endtask

  // First seed whose four corner heights all equal b.
  function automatic logic [15:0] scan_seed(input logic [7:0] b);
    logic [15:0] v0, v1, v2, v3;
    for (int s = 1; s < 65536; s++) begin
      v0 = 16'(s);
      v1 = lfsr_next(v0);
      v2 = lfsr_next(v1);
      v3 = lfsr_next(v2);
      if (v0[7:0] == b && v1[7:0] == b && v2[7:0] == b && v3[7:0] == b)
        return v0;
    end
    return 16'h0001;
  endfunction

  task automatic check_outputs_zero(input string tag);
    for (int g = 0; g < N; g++)
      chk($sformatf("%s_d%0d", tag, g),
          {busy[g], out_valid[g], out_last[g], out_x[g], out_y[g], out_z[g]}, 0);
  endtask

  task automatic run_one(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                         input bit dbl);
    logic [15:0] sd [N];
    logic all_done;
    int dim;
    logic [28:0] exp;
    sd[0] = s0; sd[1] = s1; sd[2] = s2;
    for (int g = 0; g < N; g++) begin
      got_n[g] = 0;
      fill_cnt[g] = 0;
      done[g] = 1'b0;
    end
    mon_en = 1'b1;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin seed[g] = sd[g]; start[g] = 1'b1; end
    @(negedge clk);
    for (int g = 0; g < N; g++) start[g] = 1'b0;
    if (dbl) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin seed[g] = sd[g] ^ 16'h5A5A; start[g] = 1'b1; end
      @(negedge clk);
      for (int g = 0; g < N; g++) start[g] = 1'b0;
    end
    all_done = 1'b0;
    for (int c = 0; c < 4000 && !all_done; c++) begin
      @(negedge clk);
      all_done = done[0] && done[1] && done[2];
    end
    chk("run_done", all_done, 1);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    for (int g = 0; g < N; g++) begin
      dim = (1 << dp_of(g)) + 1;
      model_run(dp_of(g), rough_of(g), sd[g]);
      chk($sformatf("d%0d_beats", g), got_n[g], dim * dim);
      chk($sformatf("d%0d_fill_cycles", g), fill_cnt[g], dim * dim);
      for (int i = 0; i < got_n[g] && i < 81; i++) begin
        exp = pack_beat(10'(i % dim), 10'(i / dim), 8'(mz[i / dim][i % dim]), i == dim * dim - 1);
        chk($sformatf("d%0d_beat%0d", g, i), got[g][i], exp);
      end
    end
  endtask

  initial begin
    logic [15:0] ff_seed, zz_seed;
    reset = 1'b1;
    for (int g = 0; g < N; g++) begin start[g] = 1'b1; seed[g] = 16'h1234; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    for (int g = 0; g < N; g++) start[g] = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("post_reset_idle");

    ff_seed = scan_seed(8'hFF);
    zz_seed = scan_seed(8'h00);

    ready_mode = 0;
    run_one(16'h0001, 16'($urandom_range(0, 65535)), ff_seed, 1'b1);
    ready_mode = 1;
    for (int it = 0; it < 4; it++)
      run_one(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
              16'($urandom_range(0, 65535)), 1'b0);
    run_one(16'($urandom_range(0, 65535)), ff_seed, zz_seed, 1'b0);

    mon_en = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin seed[g] = 16'($urandom_range(1, 65535)); start[g] = 1'b1; end
    @(negedge clk);
    for (int g = 0; g < N; g++) start[g] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("abort_reset");
    reset = 1'b0;
    ready_mode = 0;
    run_one(16'h00A5, 16'h00A5, 16'h00A5, 1'b0);
    ready_mode = 1;
    run_one(16'h0000, 16'h0000, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
